// File: rtl/uart_cmd_responder_if.sv
// FIFO-pair and register-bus signals seen by the UART command responder.
// The master modport is the responder side; slave is the FIFO/register side.
interface uart_cmd_responder_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_empty;
  logic                 rx_read_req;
  logic                 tx_full;
  logic                 tx_write_req;
  logic [DATA_BITS-1:0] tx_wdata;
  logic [ADDR_BITS-1:0] reg_addr;
  logic [DATA_BITS-1:0] reg_wdata;
  logic                 reg_we;
  logic                 reg_re;
  logic [DATA_BITS-1:0] reg_rdata;

  modport master (
    input  rx_data, rx_empty, tx_full, reg_rdata,
    output rx_read_req, tx_write_req, tx_wdata, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport slave (
    output rx_data, rx_empty, tx_full, reg_rdata,
    input  rx_read_req, tx_write_req, tx_wdata, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// Pops framed commands from the RX FIFO, performs one register read or write per frame
// and pushes a single response byte into the TX FIFO.
module uart_cmd_responder #(
  parameter int unsigned         DATA_BITS      = 8,
  parameter int unsigned         ADDR_BITS      = 8,
  parameter int unsigned         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [DATA_BITS-1:0] CMD_WR        = 8'h57,
  parameter logic [DATA_BITS-1:0] CMD_RD        = 8'h52,
  parameter logic [DATA_BITS-1:0] RSP_ACK       = 8'h06,
  parameter logic [DATA_BITS-1:0] RSP_NAK       = 8'h15
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_cmd_responder_if.master  bus,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int unsigned      CntW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0]  CntMax = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StGetAddr = 3'd1;
  localparam logic [2:0] StGetData = 3'd2;
  localparam logic [2:0] StRegWr   = 3'd3;
  localparam logic [2:0] StRegRd   = 3'd4;
  localparam logic [2:0] StRdWait  = 3'd5;
  localparam logic [2:0] StSend    = 3'd6;

  logic [2:0]           state_q, state_d;
  logic                 is_wr_q, is_wr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DATA_BITS-1:0] tx_wdata_q, tx_wdata_d;
  logic [ADDR_BITS-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_BITS-1:0] reg_wdata_q, reg_wdata_d;

  logic in_get;
  logic pop;
  logic timeout;

  assign in_get  = (state_q == StGetAddr) || (state_q == StGetData);
  assign pop     = ((state_q == StIdle) || in_get) && !bus.rx_empty;
  // A byte arriving on the last allowed cycle still wins over the abort.
  assign timeout = in_get && bus.rx_empty && (cnt_q == CntMax);

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    tx_wdata_d  = tx_wdata_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    cnt_d       = '0;
    if (in_get && bus.rx_empty && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (pop) begin
          if (bus.rx_data == CMD_WR) begin
            is_wr_d = 1'b1;
            state_d = StGetAddr;
          end else if (bus.rx_data == CMD_RD) begin
            is_wr_d = 1'b0;
            state_d = StGetAddr;
          end else begin
            tx_wdata_d = RSP_NAK;
            state_d    = StSend;
          end
        end
      end
      StGetAddr: begin
        if (timeout) begin
          state_d = StIdle;
        end else if (pop) begin
          reg_addr_d = bus.rx_data[ADDR_BITS-1:0];
          state_d    = is_wr_q ? StGetData : StRegRd;
        end
      end
      StGetData: begin
        if (timeout) begin
          state_d = StIdle;
        end else if (pop) begin
          reg_wdata_d = bus.rx_data;
          state_d     = StRegWr;
        end
      end
      StRegWr: begin
        tx_wdata_d = RSP_ACK;
        state_d    = StSend;
      end
      StRegRd: begin
        state_d = StRdWait;
      end
      StRdWait: begin
        tx_wdata_d = bus.reg_rdata;
        state_d    = StSend;
      end
      StSend: begin
        if (!bus.tx_full) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      is_wr_q     <= 1'b0;
      cnt_q       <= '0;
      tx_wdata_q  <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      cnt_q       <= cnt_d;
      tx_wdata_q  <= tx_wdata_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign bus.rx_read_req  = pop;
  assign bus.tx_write_req = (state_q == StSend) && !bus.tx_full;
  assign bus.tx_wdata     = tx_wdata_q;
  assign bus.reg_addr     = reg_addr_q;
  assign bus.reg_wdata    = reg_wdata_q;
  assign bus.reg_we       = (state_q == StRegWr);
  assign bus.reg_re       = (state_q == StRegRd);
  assign busy             = (state_q != StIdle);
  assign frame_err        = timeout;

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
Byte-level command responder that sits on the host side of the UART FIFO pair. It pops framed commands from the RX FIFO, performs single register reads and writes on a simple register bus, and pushes one response byte per frame into the TX FIFO. It is the protocol endpoint that answers a remote initiator talking over the UART link.

Parameters:
DATA_BITS, 8, width of UART bytes, register data and response bytes
ADDR_BITS, 8, register address width; must be <= DATA_BITS and is taken from the low bits of the address byte
TIMEOUT_CYCLES, 1_000_000, idle clk cycles allowed between bytes of one frame before the frame is aborted; must be >= 2
CMD_WR, 8'h57, command byte for a write frame
CMD_RD, 8'h52, command byte for a read frame
RSP_ACK, 8'h06, response byte for a completed write
RSP_NAK, 8'h15, response byte for an unknown command

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_data  in  DATA_BITS  head byte of RX FIFO; valid whenever rx_empty=0 (first-word-fall-through)
rx_empty  in  1  RX FIFO empty
rx_read_req  out  1  pop RX FIFO this cycle
tx_full  in  1  TX FIFO full
tx_write_req  out  1  push tx_wdata into TX FIFO this cycle
tx_wdata  out  DATA_BITS  response byte
reg_addr  out  ADDR_BITS  register bus address
reg_wdata  out  DATA_BITS  register bus write data
reg_we  out  1  one-cycle register write strobe
reg_re  out  1  one-cycle register read strobe
reg_rdata  in  DATA_BITS  read data, valid the cycle after reg_re
busy  out  1  high in every state except IDLE
frame_err  out  1  one-cycle pulse on frame timeout

Behaviour:
- Frames: write = CMD_WR, ADDR, DATA -> reply RSP_ACK. Read = CMD_RD, ADDR -> reply the register value. Any other first byte -> reply RSP_NAK; no further bytes are consumed for that frame.
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0: tx_wdata, reg_addr, reg_wdata, strobes, busy, frame_err. Timeout counter=0. Reset mid-frame discards the partial frame. Bytes already in the FIFOs are untouched.
- rx_read_req is combinational: 1 iff state is IDLE, GET_ADDR or GET_DATA and rx_empty=0. The byte is captured on that clock edge.
- States:
  - IDLE: on pop, CMD_WR/CMD_RD -> GET_ADDR and latch the command; other byte -> load RSP_NAK into tx_wdata -> SEND.
  - GET_ADDR: on pop, reg_addr <= rx_data[ADDR_BITS-1:0]. If command is write -> GET_DATA, else -> REG_RD.
  - GET_DATA: on pop, reg_wdata <= rx_data -> REG_WR.
  - REG_WR: reg_we=1 for exactly this cycle; tx_wdata <= RSP_ACK -> SEND.
  - REG_RD: reg_re=1 for exactly this cycle -> RD_WAIT.
  - RD_WAIT: tx_wdata <= reg_rdata -> SEND.
  - SEND: tx_write_req combinational = !tx_full. When tx_write_req=1 -> IDLE. While tx_full=1, hold SEND with tx_wdata stable (backpressure, no timeout).
- Latency from the last byte's pop edge to tx_write_req high, with tx_full=0: write = 2 cycles (REG_WR, SEND); read = 3 cycles (REG_RD, RD_WAIT, SEND); NAK = 1 cycle.
- Timeout: the counter increments each cycle in GET_ADDR or GET_DATA while rx_empty=1, and clears on every pop and in every other state. On the cycle the counter equals TIMEOUT_CYCLES-1: frame_err=1 for one cycle, -> IDLE, no response, and no reg_we/reg_re.
- The counter width is $clog2(TIMEOUT_CYCLES). It never wraps.
- reg_addr and reg_wdata hold their last values between frames.
- Frames are processed strictly one at a time. A new command is not popped until SEND completes, even if RX bytes are waiting.

Test Plan:
- Write: push 57,3C,A5 into RX with tx_full=0 -> one reg_we pulse with reg_addr=3C, reg_wdata=A5; then exactly one tx_write_req with tx_wdata=06; busy returns to 0.
- Read: model returns 5A for addr 10; push 52,10 -> reg_re pulse at addr 10 and no reg_we; tx_wdata=5A written 3 cycles after the address pop.
- Unknown command: push 41,52,07 -> NAK (15) written after 41. Then 52,07 is processed as a read of addr 07. Exactly 2 TX writes total.
- Backpressure: tx_full=1 during a write frame -> state holds SEND, tx_write_req=0, tx_wdata=06 stable. Release after 50 cycles -> single write of 06; no RX pop occurs while in SEND.
- Timeout with TIMEOUT_CYCLES=16: push 57,20 only -> frame_err pulses exactly 16 cycles into the gap after the pop of 20. No reg_we, no TX write. A following 52,20 frame completes normally.
- Reset mid-frame: push 57,01, then assert reset low for 1 cycle -> outputs 0 asynchronously and state IDLE. The next byte 52 is treated as a command.
